// File: rtl/scandoubler_pkg.sv
// Shared widths, default timing and small helpers for the scan doubler.
package scandoubler_pkg;

    // Data and address widths.
    localparam int COLOR_W = 8;
    localparam int BUF_AW  = 8;   // 160 entries per bank
    localparam int OC_W    = 9;   // output counter covers 0..455

    // Default timing: output clocks per line, active width, first active h, sync width.
    localparam int DEF_H_TOTAL  = 228;
    localparam int DEF_ACTIVE_W = 160;
    localparam int DEF_H_START  = 68;
    localparam int DEF_HS_LEN   = 16;

    localparam logic [COLOR_W-1:0] DEF_BLANK_COLOR = 8'h00;

    // Vertical flags carried from the input line to the output pair.
    typedef struct packed {
        logic vsync;
        logic vblank;
    } vflags_t;

    localparam vflags_t VFLAGS_RESET = '{vsync: 1'b0, vblank: 1'b1};

    // Fold the double-line counter onto a single output line position.
    function automatic logic [OC_W-1:0] fold_oc(input logic [OC_W-1:0] oc,
                                                input logic [OC_W-1:0] h_total);
        return (oc >= h_total) ? (oc - h_total) : oc;
    endfunction

endpackage

// File: rtl/line_buffer_2x.sv
// Two-bank line store: one bank fills from the TIA while the other replays.
// Simple dual-port RAM, registered read, no reset on storage or read data so
// it maps onto a block RAM.
module line_buffer_2x
    import scandoubler_pkg::*;
#(
    parameter int DEPTH = DEF_ACTIVE_W
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic               wr_bank,
    input  logic [BUF_AW-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               rd_bank,
    input  logic [BUF_AW-1:0]  rd_addr,
    output logic [COLOR_W-1:0] rd_data
);

    localparam logic [BUF_AW:0] BANK_OFS = (BUF_AW+1)'(DEPTH);

    // Bank 1 lives directly above bank 0 in one flat array.
    logic [COLOR_W-1:0] mem [0:2*DEPTH-1];
    logic [BUF_AW:0]    wr_idx;
    logic [BUF_AW:0]    rd_idx;

    assign wr_idx = wr_bank ? (BANK_OFS + {1'b0, wr_addr}) : {1'b0, wr_addr};
    assign rd_idx = rd_bank ? (BANK_OFS + {1'b0, rd_addr}) : {1'b0, rd_addr};

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read port, one cycle of latency.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/video_scandoubler.sv
// Line-doubling scan converter: captures each active TIA line into one bank
// of a ping-pong buffer and replays the previously captured line twice at
// twice the pixel rate, giving 31.4 kHz progressive timing.
//
// Input qualifier: PIX_EN is a one-cycle strobe, high every second CLOCKVGA.
// COLOR_IN and all sync/blank inputs are sampled only on PIX_EN cycles; there
// is no back-pressure, every qualified sample is consumed on that cycle.
module video_scandoubler
    import scandoubler_pkg::*;
#(
    parameter int                 H_TOTAL     = DEF_H_TOTAL,
    parameter int                 ACTIVE_W    = DEF_ACTIVE_W,
    parameter int                 H_START     = DEF_H_START,
    parameter int                 HS_LEN      = DEF_HS_LEN,
    parameter logic [COLOR_W-1:0] BLANK_COLOR = DEF_BLANK_COLOR
) (
    input  logic               CLOCKVGA,
    input  logic               RES,
    input  logic               PIX_EN,
    input  logic [COLOR_W-1:0] COLOR_IN,
    input  logic               HSYNC_IN,
    input  logic               HBLANK_IN,
    input  logic               VSYNC_IN,
    input  logic               VBLANK_IN,
    output logic [COLOR_W-1:0] COLOR_OUT,
    output logic               HSYNC_OUT,
    output logic               HBLANK_OUT,
    output logic               VSYNC_OUT,
    output logic               VBLANK_OUT,
    output logic               LINE_ODD
);

    localparam logic [OC_W-1:0]   OC_LAST = OC_W'(2*H_TOTAL - 1);
    localparam logic [OC_W-1:0]   H_TOT   = OC_W'(H_TOTAL);
    localparam logic [OC_W-1:0]   H_ST    = OC_W'(H_START);
    localparam logic [OC_W-1:0]   H_END   = OC_W'(H_START + ACTIVE_W);
    localparam logic [OC_W-1:0]   HS_END  = OC_W'(HS_LEN);
    localparam logic [BUF_AW-1:0] WR_MAX  = BUF_AW'(ACTIVE_W);

    // Write side state.
    logic              hsync_q;
    logic              hs_edge;
    logic              hs_edge_q;
    logic              wr_bank;
    logic              wr_en;
    logic [BUF_AW-1:0] wr_x;
    vflags_t           v_lat;

    // Read / timing side.
    logic [OC_W-1:0]    oc;
    logic [OC_W-1:0]    h;
    logic               odd;
    logic               active;
    logic               rd_bank;
    logic [BUF_AW-1:0]  rd_addr;
    logic [COLOR_W-1:0] rd_data;

    // Stage aligned with the buffer read data.
    logic    act_q;
    logic    hs_q;
    logic    odd_q;
    vflags_t v_q;

    // Rising HSYNC on a qualified sample starts a new input line.
    assign hs_edge = PIX_EN & HSYNC_IN & ~hsync_q;

    // Capture only inside the input active window and only until the bank is
    // full; surplus pixels of an overlong line are dropped, never wrapped.
    assign wr_en = PIX_EN & ~HBLANK_IN & (wr_x < WR_MAX);

    // The replayed line is the one completed before the last swap.
    assign rd_bank = ~wr_bank;
    assign odd     = (oc >= H_TOT);
    assign h       = fold_oc(oc, H_TOT);
    assign active  = (h >= H_ST) && (h < H_END);
    assign rd_addr = active ? BUF_AW'(h - H_ST) : '0;

    // Track input HSYNC, swap banks and latch vertical flags at each line start.
    // A pixel written on the same strobe as the edge still lands in the old
    // bank, because the bank select only changes after this edge.
    always_ff @(posedge CLOCKVGA or posedge RES) begin
        if (RES) begin
            hsync_q   <= 1'b0;
            hs_edge_q <= 1'b0;
            wr_bank   <= 1'b0;
            wr_x      <= '0;
            v_lat     <= VFLAGS_RESET;
        end else begin
            hs_edge_q <= hs_edge;
            if (PIX_EN) begin
                hsync_q <= HSYNC_IN;
            end
            if (hs_edge) begin
                wr_bank <= ~wr_bank;
                wr_x    <= '0;
                v_lat   <= '{vsync: VSYNC_IN, vblank: VBLANK_IN};
            end else if (wr_en) begin
                wr_x <= wr_x + 1'b1;
            end
        end
    end

    // Double-line output counter; a fresh input line restarts it, truncating
    // whatever output line was in progress. Without HSYNC it free-runs and
    // the same bank keeps replaying.
    always_ff @(posedge CLOCKVGA or posedge RES) begin
        if (RES) begin
            oc <= '0;
        end else if (hs_edge_q || (oc == OC_LAST)) begin
            oc <= '0;
        end else begin
            oc <= oc + 1'b1;
        end
    end

    line_buffer_2x #(
        .DEPTH(ACTIVE_W)
    ) u_line_buffer (
        .clk     (CLOCKVGA),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (wr_x),
        .wr_data (COLOR_IN),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Delay timing flags to line up with the registered buffer read; vertical
    // flags are picked up only at the start of an output pair.
    always_ff @(posedge CLOCKVGA or posedge RES) begin
        if (RES) begin
            act_q <= 1'b0;
            hs_q  <= 1'b0;
            odd_q <= 1'b0;
            v_q   <= VFLAGS_RESET;
        end else begin
            act_q <= active;
            hs_q  <= (h < HS_END);
            odd_q <= odd;
            if (oc == '0) begin
                v_q <= v_lat;
            end
        end
    end

    // Output registers, two cycles after the h value that produced them.
    always_ff @(posedge CLOCKVGA or posedge RES) begin
        if (RES) begin
            COLOR_OUT  <= BLANK_COLOR;
            HSYNC_OUT  <= 1'b0;
            HBLANK_OUT <= 1'b1;
            VSYNC_OUT  <= 1'b0;
            VBLANK_OUT <= 1'b1;
            LINE_ODD   <= 1'b0;
        end else begin
            COLOR_OUT  <= act_q ? rd_data : BLANK_COLOR;
            HSYNC_OUT  <= hs_q;
            HBLANK_OUT <= ~act_q;
            VSYNC_OUT  <= v_q.vsync;
            VBLANK_OUT <= v_q.vblank;
            LINE_ODD   <= odd_q;
        end
    end

endmodule

// File: tb/tb_video_scandoubler.sv
// Bench for video_scandoubler: a stream of TIA-style input lines (table rows
// followed by randomized rows) against a line-level reference model.
module tb_video_scandoubler;

    localparam int W      = 26;   // packed expected record
    localparam int HT     = 228;
    localparam int AW     = 160;
    localparam int HSTART = 68;
    localparam int HSLEN  = 16;
    localparam int LINE   = 2*HT;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       RES = 1'b1;
    logic       PIX_EN = 1'b0;
    logic [7:0] COLOR_IN = 8'h00;
    logic       HSYNC_IN = 1'b0;
    logic       HBLANK_IN = 1'b1;
    logic       VSYNC_IN = 1'b0;
    logic       VBLANK_IN = 1'b0;
    logic [7:0] COLOR_OUT;
    logic       HSYNC_OUT;
    logic       HBLANK_OUT;
    logic       VSYNC_OUT;
    logic       VBLANK_OUT;
    logic       LINE_ODD;

    always #5 clk = ~clk;

    video_scandoubler dut (
        .CLOCKVGA   (clk),
        .RES        (RES),
        .PIX_EN     (PIX_EN),
        .COLOR_IN   (COLOR_IN),
        .HSYNC_IN   (HSYNC_IN),
        .HBLANK_IN  (HBLANK_IN),
        .VSYNC_IN   (VSYNC_IN),
        .VBLANK_IN  (VBLANK_IN),
        .COLOR_OUT  (COLOR_OUT),
        .HSYNC_OUT  (HSYNC_OUT),
        .HBLANK_OUT (HBLANK_OUT),
        .VSYNC_OUT  (VSYNC_OUT),
        .VBLANK_OUT (VBLANK_OUT),
        .LINE_ODD   (LINE_ODD)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Two banks of captured lines, which input row each bank holds, and the
    // output position derived from the cycle at which the last line started.
    logic [7:0] m_buf   [2][AW];
    bit         m_known [2][AW];
    logic [3:0] m_tag   [2];
    bit         m_bank;
    int         m_wr_x;
    bit         m_hs_prev;
    logic [1:0] m_vlat;
    logic [1:0] m_vdisp;
    int         m_cyc;
    int         m_zero;
    int         m_zero_new;
    logic [3:0] cur_row = 4'hF;
    bit         model_ready = 1'b0;

    // record: tag[25:22] h[21:14] known[13] color[12:5] hs[4] hb[3] vs,vb[2:1] odd[0]
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] pack_rec(logic [3:0] tag, logic [7:0] h, bit known,
                                              logic [7:0] col, bit hs, bit hb,
                                              logic [1:0] v, bit odd);
        return {tag, h, known, col, hs, hb, v, odd};
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int x = 0; x < AW; x++) m_known[b][x] = 1'b0;
            m_tag[b] = 4'hF;
        end
        m_bank     = 1'b0;
        m_wr_x     = 0;
        m_hs_prev  = 1'b0;
        m_vlat     = 2'b01;
        m_vdisp    = 2'b01;
        m_cyc      = 0;
        m_zero     = 0;
        m_zero_new = -1;
        exp_q.delete();
        // two cycles of reset-valued output still in flight after release
        exp_q.push_back(pack_rec(4'hF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0));
        exp_q.push_back(pack_rec(4'hF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0));
    endtask

    task automatic model_step();
        int         oc;
        int         h;
        int         a;
        bit         act;
        bit         rb;
        bit         known;
        bit         edge_seen;
        logic [7:0] col;
        if (m_cyc == m_zero_new) m_zero = m_zero_new;
        oc  = (m_cyc - m_zero) % LINE;
        h   = (oc < HT) ? oc : oc - HT;
        act = (h >= HSTART) && (h < HSTART + AW);
        rb  = ~m_bank;
        col = 8'h00;
        known = 1'b1;
        if (act) begin
            a     = h - HSTART;
            col   = m_buf[rb][a];
            known = m_known[rb][a];
        end
        if (oc == 0) m_vdisp = m_vlat;
        exp_q.push_back(pack_rec(m_tag[rb], 8'(h), known, col, h < HSLEN, !act,
                                 m_vdisp, oc >= HT));
        void'(exp_q.pop_front());
        edge_seen = 1'b0;
        if (PIX_EN) begin
            edge_seen = HSYNC_IN && !m_hs_prev;
            if (!HBLANK_IN && m_wr_x < AW) begin
                m_buf[m_bank][m_wr_x]   = COLOR_IN;
                m_known[m_bank][m_wr_x] = 1'b1;
                m_wr_x++;
            end
            if (edge_seen) begin
                m_bank        = ~m_bank;
                m_wr_x        = 0;
                m_vlat        = {VSYNC_IN, VBLANK_IN};
                m_tag[m_bank] = cur_row;
                m_zero_new    = m_cyc + 2;   // output line restarts two clocks on
            end
            m_hs_prev = HSYNC_IN;
        end
        m_cyc++;
    endtask

    always @(posedge clk) begin
        if (RES) begin
            model_reset();
            model_ready = 1'b1;
        end else if (model_ready) begin
            model_step();
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] obs_c68  [16][2];
    logic [7:0] obs_c227 [16][2];
    logic [1:0] obs_v    [16][2];
    bit         obs_seen [16][2];

    initial begin
        for (int t = 0; t < 16; t++) begin
            obs_seen[t][0] = 1'b0;
            obs_seen[t][1] = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [12:0]  got;
        int           tg;
        int           od;
        got = {COLOR_OUT, HSYNC_OUT, HBLANK_OUT, VSYNC_OUT, VBLANK_OUT, LINE_ODD};
        if (model_ready) begin
            checks++;
            if (RES) begin
                if (got !== 13'b00000000_0_1_0_1_0) begin
                    errors++;
                    $display("FAIL reset_outputs t=%0t got=%h want=%h", $time, got,
                             13'b00000000_0_1_0_1_0);
                end
            end else begin
                e = exp_q[0];
                if (e[13] ? (got !== e[12:0]) : (got[4:0] !== e[4:0])) begin
                    errors++;
                    $display("FAIL stream t=%0t h=%0d odd=%0d got col=%h hs=%b hb=%b vs=%b vb=%b odd=%b want col=%h(known=%b) hs=%b hb=%b vs=%b vb=%b odd=%b",
                             $time, e[21:14], e[0], COLOR_OUT, HSYNC_OUT, HBLANK_OUT,
                             VSYNC_OUT, VBLANK_OUT, LINE_ODD, e[12:5], e[13], e[4], e[3],
                             e[2], e[1], e[0]);
                end
                tg = int'(e[25:22]);
                od = int'(e[0]);
                if (e[21:14] == 8'd68)  obs_c68[tg][od]  = COLOR_OUT;
                if (e[21:14] == 8'd227) obs_c227[tg][od] = COLOR_OUT;
                if (e[21:14] == 8'd100) begin
                    obs_v[tg][od]    = {VSYNC_OUT, VBLANK_OUT};
                    obs_seen[tg][od] = 1'b1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    // kind: 0 ramp idx, 1 constant param, 2 idx+1, 3 random, 4 8'h80+idx
    task automatic drive_line(input int kind, input logic [7:0] param, input bit with_hs,
                              input bit vs, input bit vb, input int n_act, input int rst_at);
        int p;
        int idx;
        int a0;
        a0 = HT - n_act;
        for (int i = 0; i < LINE; i++) begin
            p   = i / 2;
            idx = p - a0;
            @(posedge clk);
            #1;
            RES       = (rst_at >= 0) && (i >= 2*rst_at) && (i < 2*rst_at + 10);
            PIX_EN    = (i % 2 == 0);
            HSYNC_IN  = with_hs && (p < HSLEN);
            HBLANK_IN = (p < a0);
            VSYNC_IN  = vs;
            VBLANK_IN = vb;
            if (p < a0)          COLOR_IN = 8'($urandom);
            else if (kind == 0)  COLOR_IN = 8'(idx);
            else if (kind == 1)  COLOR_IN = param;
            else if (kind == 2)  COLOR_IN = 8'(idx + 1);
            else if (kind == 4)  COLOR_IN = 8'(8'h80 + idx);
            else                 COLOR_IN = 8'($urandom);
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        int         kind;
        logic [7:0] param;
        bit         hs;
        bit         vs;
        bit         vb;
        int         n_act;
        bit         disp;     // this row is shown as an output pair before the end
        bit         chk_col;  // probe colours are fixed for this row
        logic [7:0] c68;      // expected colour at h=68 on both replays
        logic [7:0] c227;     // expected colour at h=227 on both replays
        logic [1:0] ev;       // expected {VSYNC_OUT,VBLANK_OUT} while this row is shown
    } row_t;

    row_t rows [15];

    initial begin
        rows[0]  = '{0, 8'h00, 1, 0, 0, 160, 1, 1, 8'h00, 8'h9F, 2'b00};  // ramp
        rows[1]  = '{1, 8'h1E, 1, 0, 0, 160, 1, 1, 8'h1E, 8'h1E, 2'b00};  // ping-pong
        rows[2]  = '{1, 8'h44, 1, 0, 0, 160, 1, 1, 8'h44, 8'h44, 2'b00};
        rows[3]  = '{1, 8'h1E, 1, 0, 0, 160, 1, 1, 8'h1E, 8'h1E, 2'b00};
        rows[4]  = '{1, 8'h44, 1, 0, 0, 160, 1, 1, 8'h44, 8'h44, 2'b00};
        rows[5]  = '{2, 8'h00, 1, 0, 0, 200, 1, 1, 8'h01, 8'hA0, 2'b11};  // overlong; shown under row 6 flags
        rows[6]  = '{1, 8'h55, 1, 1, 1, 160, 1, 1, 8'h55, 8'h55, 2'b00};  // carries VSYNC/VBLANK
        rows[7]  = '{3, 8'h00, 1, 0, 0, 160, 1, 0, 8'h00, 8'h00, 2'b00};
        rows[8]  = '{4, 8'h00, 1, 0, 0, 100, 1, 1, 8'h80, 8'h55, 2'b00};  // short: stale tail from row 6
        rows[9]  = '{0, 8'h00, 1, 0, 0, 160, 1, 1, 8'h00, 8'h9F, 2'b00};
        rows[10] = '{3, 8'h00, 0, 0, 0, 160, 0, 0, 8'h00, 8'h00, 2'b00};  // no HSYNC x3
        rows[11] = '{3, 8'h00, 0, 1, 0, 160, 0, 0, 8'h00, 8'h00, 2'b00};
        rows[12] = '{3, 8'h00, 0, 0, 1, 160, 0, 0, 8'h00, 8'h00, 2'b00};
        rows[13] = '{1, 8'h2A, 1, 0, 0, 160, 1, 1, 8'h2A, 8'h2A, 2'b00};
        rows[14] = '{1, 8'h3C, 1, 0, 0, 160, 0, 0, 8'h00, 8'h00, 2'b00};

        // power-on reset, held across several clocks
        RES = 1'b1;
        repeat (6) @(posedge clk);

        for (int r = 0; r < 15; r++) begin
            cur_row = 4'(r);
            drive_line(rows[r].kind, rows[r].param, rows[r].hs, rows[r].vs, rows[r].vb,
                       rows[r].n_act, -1);
        end

        // randomized rows, with one reset pulse mid-line
        cur_row = 4'hF;
        for (int r = 0; r < 24; r++) begin
            drive_line(3, 8'h00, $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(120, 200),
                       (r == 8) ? $urandom_range(20, 200) : -1);
        end
        repeat (4) @(posedge clk);
        #1;

        // per-row probes on the output pair that replayed each table row
        for (int r = 0; r < 15; r++) begin
            if (rows[r].disp) begin
                for (int od = 0; od < 2; od++) begin
                    checks++;
                    if (!obs_seen[r][od]) begin
                        errors++;
                        $display("FAIL row%0d_shown odd=%0d got=not shown want=shown", r, od);
                    end else begin
                        if (obs_v[r][od] !== rows[r].ev) begin
                            errors++;
                            $display("FAIL row%0d_vflags odd=%0d got=%b want=%b", r, od,
                                     obs_v[r][od], rows[r].ev);
                        end
                        if (rows[r].chk_col) begin
                            checks++;
                            if (obs_c68[r][od] !== rows[r].c68) begin
                                errors++;
                                $display("FAIL row%0d_h68 odd=%0d got=%h want=%h", r, od,
                                         obs_c68[r][od], rows[r].c68);
                            end
                            checks++;
                            if (obs_c227[r][od] !== rows[r].c227) begin
                                errors++;
                                $display("FAIL row%0d_h227 odd=%0d got=%h want=%h", r, od,
                                         obs_c227[r][od], rows[r].c227);
                            end
                        end
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
